cp0_exc_unit: RTL and testbench

- Coprocessor-0 exception/interrupt responder for the 5-stage MIPS pipeline.
- Consumes exception reports from the pipeline, including the fetch-stage misaligned-PC flag (AdEL, ExcCode 4), and the six hardware interrupt lines.
- Drives INT_REQ back to fetch and the pipeline flush logic.
- Holds SR/Cause/EPC/PRId, serves mfc0/mtc0, and supplies the handler address and the eret return address.

---
 rtl/cp0_exc_unit_if.sv | 27 ++
 rtl/cp0_exc_unit.sv | 101 ++++++++++
 tb/tb_cp0_exc_unit.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/cp0_exc_unit_if.sv
// rtl/cp0_exc_unit_if.sv - pipeline-side bus into the CP0 exception unit
interface cp0_exc_unit_if;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] DIn;
    logic        We;
    logic [31:0] VPC;
    logic        BD;
    logic        ExcReq;
    logic [4:0]  ExcCode;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic [31:0] DOut;
    logic        INT_REQ;
    logic [31:0] ExcNPC;
    logic [31:0] EPC;

    modport master (
        output A1, A2, DIn, We, VPC, BD, ExcReq, ExcCode, HWInt, EXLClr,
        input  DOut, INT_REQ, ExcNPC, EPC
    );

    modport slave (
        input  A1, A2, DIn, We, VPC, BD, ExcReq, ExcCode, HWInt, EXLClr,
        output DOut, INT_REQ, ExcNPC, EPC
    );
endinterface

// File: rtl/cp0_exc_unit.sv
// rtl/cp0_exc_unit.sv - CP0 SR/Cause/EPC/PRId with exception and interrupt entry
module cp0_exc_unit #(
    parameter logic [31:0] PRID_VALUE   = 32'h4D495053,
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
) (
    input  logic               clk,
    input  logic               reset,
    cp0_exc_unit_if.slave      bus
);

    typedef enum logic {
        MODE_NORMAL  = 1'b0,
        MODE_HANDLER = 1'b1
    } mode_t;

    mode_t       mode_q, mode_d;
    logic [5:0]  im_q, im_d;
    logic        ie_q, ie_d;
    logic [5:0]  ip_q, ip_d;
    logic        bd_q, bd_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [31:0] epc_q, epc_d;

    logic        exl;
    logic        int_pend;
    logic        int_req;
    logic [31:0] victim_pc;

    assign exl      = (mode_q == MODE_HANDLER);
    assign int_pend = (|(bus.HWInt & im_q)) & ie_q & ~exl;
    assign int_req  = (int_pend | bus.ExcReq) & ~exl;

    // A delay-slot victim restarts at its branch so the branch re-executes.
    assign victim_pc = bus.BD ? (bus.VPC - 32'd4) : bus.VPC;

    assign bus.INT_REQ = int_req;
    assign bus.ExcNPC  = HANDLER_ADDR;
    assign bus.EPC     = epc_q;

    always_comb begin
        mode_d     = mode_q;
        im_d       = im_q;
        ie_d       = ie_q;
        ip_d       = bus.HWInt;
        bd_d       = bd_q;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;

        if (int_req) begin
            mode_d     = MODE_HANDLER;
            exc_code_d = int_pend ? 5'd0 : bus.ExcCode;
            bd_d       = bus.BD;
            epc_d      = {victim_pc[31:2], 2'b00};
        end else begin
            if (bus.We && (bus.A2 == 5'd12)) begin
                im_d   = bus.DIn[15:10];
                ie_d   = bus.DIn[0];
                mode_d = bus.DIn[1] ? MODE_HANDLER : MODE_NORMAL;
            end
            if (bus.We && (bus.A2 == 5'd14)) begin
                epc_d = {bus.DIn[31:2], 2'b00};
            end
            // eret overrides an EXL value written by a colliding mtc0.
            if (bus.EXLClr && exl) begin
                mode_d = MODE_NORMAL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mode_q     <= MODE_NORMAL;
            im_q       <= 6'd0;
            ie_q       <= 1'b0;
            ip_q       <= 6'd0;
            bd_q       <= 1'b0;
            exc_code_q <= 5'd0;
            epc_q      <= 32'd0;
        end else begin
            mode_q     <= mode_d;
            im_q       <= im_d;
            ie_q       <= ie_d;
            ip_q       <= ip_d;
            bd_q       <= bd_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
        end
    end

    always_comb begin
        bus.DOut = 32'd0;
        case (bus.A1)
            5'd12:   bus.DOut = {16'd0, im_q, 8'd0, exl, ie_q};
            5'd13:   bus.DOut = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'd0};
            5'd14:   bus.DOut = epc_q;
            5'd15:   bus.DOut = PRID_VALUE;
            default: bus.DOut = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// tb/tb_cp0_exc_unit.sv - randomized and directed checks of cp0_exc_unit against a register-word model
module tb_cp0_exc_unit;

    localparam logic [31:0] PRID    = 32'h4D495053;
    localparam logic [31:0] HANDLER = 32'h0000_4180;

    logic clk;
    logic reset;
    cp0_exc_unit_if bus();

    cp0_exc_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state held as the architectural register words.
    logic [31:0] sr_m;
    logic [31:0] cause_m;
    logic [31:0] epc_m;
    logic        model_valid;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic m_pend();
        return (|(bus.HWInt & sr_m[15:10])) & sr_m[0] & ~sr_m[1];
    endfunction

    function automatic logic m_req();
        return (m_pend() | bus.ExcReq) & ~sr_m[1];
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd12:   return sr_m;
            5'd13:   return cause_m;
            5'd14:   return epc_m;
            5'd15:   return PRID;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_edge();
        logic        req, pend, old_exl;
        logic [31:0] v;
        if (!reset) begin
            sr_m = 0; cause_m = 0; epc_m = 0;
            model_valid = 1'b1;
            return;
        end
        req = m_req(); pend = m_pend(); old_exl = sr_m[1];
        cause_m[15:10] = bus.HWInt;
        if (req) begin
            sr_m[1] = 1'b1;
            cause_m[6:2] = pend ? 5'd0 : bus.ExcCode;
            cause_m[31] = bus.BD;
            v = bus.BD ? bus.VPC - 32'd4 : bus.VPC;
            epc_m = v & ~32'd3;
        end else begin
            if (bus.We && bus.A2 == 5'd12) sr_m = bus.DIn & 32'h0000_FC03;
            if (bus.We && bus.A2 == 5'd14) epc_m = bus.DIn & ~32'd3;
            if (bus.EXLClr && old_exl) sr_m[1] = 1'b0;
        end
    endtask

    // Inputs are set just after a negedge; outputs checked 1ns later, model advances on posedge.
    task automatic tick();
        #1;
        if (model_valid && reset) begin
            check("int_req", {31'd0, bus.INT_REQ}, {31'd0, m_req()});
            check("dout", bus.DOut, m_read(bus.A1));
            check("epc", bus.EPC, epc_m);
            check("exc_npc", bus.ExcNPC, HANDLER);
        end
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic peek(input string tag, input logic [4:0] a, input logic [31:0] exp);
        bus.A1 = a;
        #1;
        check(tag, bus.DOut, exp);
    endtask

    task automatic idle();
        bus.A1 = 5'd0; bus.A2 = 5'd0; bus.DIn = 32'd0; bus.We = 1'b0;
        bus.VPC = 32'd0; bus.BD = 1'b0; bus.ExcReq = 1'b0; bus.ExcCode = 5'd0;
        bus.HWInt = 6'd0; bus.EXLClr = 1'b0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        idle();
        bus.We = 1'b1; bus.A2 = a; bus.DIn = d;
        tick();
    endtask

    initial begin
        sr_m = 0; cause_m = 0; epc_m = 0; model_valid = 1'b0;
        idle();
        reset = 1'b0;
        bus.HWInt = 6'h3F; bus.ExcReq = 1'b1;
        @(negedge clk);
        tick();
        tick();
        reset = 1'b1;
        idle();
        #1;
        check("rst_int_req", {31'd0, bus.INT_REQ}, 32'd0);
        peek("rst_sr", 5'd12, 32'd0);
        peek("rst_prid", 5'd15, PRID);
        check("rst_epc", bus.EPC, 32'd0);
        tick();

        // Fetch AdEL with interrupts enabled but none pending.
        mtc0(5'd12, 32'h0000_FC01);
        idle();
        bus.VPC = 32'h0000_3006; bus.ExcReq = 1'b1; bus.ExcCode = 5'd4;
        #1;
        check("adel_req", {31'd0, bus.INT_REQ}, 32'd1);
        tick();
        #1;
        check("adel_held_req", {31'd0, bus.INT_REQ}, 32'd0);
        peek("adel_cause", 5'd13, 32'h0000_0010);
        peek("adel_sr", 5'd12, 32'h0000_FC03);
        check("adel_epc", bus.EPC, 32'h0000_3004);
        tick();

        // eret, then masked vs unmasked interrupt.
        idle(); bus.EXLClr = 1'b1; tick();
        mtc0(5'd12, 32'h0000_0401);
        idle(); bus.HWInt = 6'b000010;
        #1;
        check("masked_req", {31'd0, bus.INT_REQ}, 32'd0);
        tick();
        bus.A1 = 5'd13; #1;
        check("cause_ip", {26'd0, bus.DOut[15:10]}, 32'd2);
        bus.HWInt = 6'b000001;
        #1;
        check("unmasked_req", {31'd0, bus.INT_REQ}, 32'd1);
        tick();
        bus.A1 = 5'd13; #1;
        check("int_code", {27'd0, bus.DOut[6:2]}, 32'd0);

        // Delay-slot victim with interrupt beating overflow.
        idle(); bus.EXLClr = 1'b1; tick();
        idle();
        bus.HWInt = 6'd1; bus.ExcReq = 1'b1; bus.ExcCode = 5'd12;
        bus.BD = 1'b1; bus.VPC = 32'h0000_3010;
        tick();
        idle(); bus.HWInt = 6'd1;
        #1;
        check("bd_epc", bus.EPC, 32'h0000_300C);
        peek("bd_cause", 5'd13, 32'h8000_0400);

        // eret colliding with mtc0 to SR.
        idle();
        bus.HWInt = 6'd1; bus.EXLClr = 1'b1; bus.We = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0403;
        #1;
        check("eret_cycle_req", {31'd0, bus.INT_REQ}, 32'd0);
        tick();
        idle(); bus.HWInt = 6'd1;
        peek("eret_sr", 5'd12, 32'h0000_0401);
        check("after_eret_req", {31'd0, bus.INT_REQ}, 32'd1);
        tick();

        // mtc0 EPC dropped by a simultaneous exception.
        idle(); bus.EXLClr = 1'b1; tick();
        idle();
        bus.We = 1'b1; bus.A2 = 5'd14; bus.DIn = 32'h1234_5678;
        bus.ExcReq = 1'b1; bus.ExcCode = 5'd10; bus.VPC = 32'h0000_3000;
        tick();
        idle();
        #1;
        check("mtc0_drop_epc", bus.EPC, 32'h0000_3000);

        for (int i = 0; i < 3000; i++) begin
            logic [4:0] codes [4];
            codes[0] = 5'd4; codes[1] = 5'd5; codes[2] = 5'd10; codes[3] = 5'd12;
            reset       = ($urandom_range(0, 199) != 0);
            bus.A1      = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(12 + $urandom_range(0, 3));
            bus.A2      = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(12 + $urandom_range(0, 3));
            bus.DIn     = $urandom;
            bus.We      = ($urandom_range(0, 2) == 0);
            bus.VPC     = $urandom;
            bus.BD      = $urandom_range(0, 1) == 1;
            bus.ExcReq  = ($urandom_range(0, 5) == 0);
            bus.ExcCode = codes[$urandom_range(0, 3)];
            bus.HWInt   = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom);
            bus.EXLClr  = sr_m[1] ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
